// File: rtl/crc32_stream.sv
// crc32_stream -- streaming CRC-32 engine for the Ethernet MAC datapath.
//
// A frame arrives as DATA_W-bit beats with a per-byte keep mask. The beat
// carrying in_last closes the frame. One cycle later the reflected, inverted
// FCS is presented together with a residue flag (RX check), a keep-violation
// flag and a saturating byte count.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   in_valid   beat present
//   in_ready   beat accepted when in_valid & in_ready
//   in_data    beat data, lane 0 = in_data[7:0] = first byte on the wire
//   in_keep    byte-valid mask, one bit per lane
//   in_last    final beat of the frame
//   in_abort   discard the current frame (ignored while the result is shown)
//   out_valid  one-cycle result strobe
//   out_crc    final CRC after output reflection and XOROUT
//   out_ok     out_crc equals RESIDUE (good frame with FCS included)
//   out_err    keep violation seen in the frame
//   out_bytes  bytes counted in the frame, saturating at 16'hFFFF
//
// State | meaning
// IDLE  | waiting for the first beat, accumulator holds INIT
// ACC   | inside a frame, folding each accepted beat
// DONE  | result strobe cycle, input stalled
module crc32_stream #(
    parameter int          DATA_W  = 8,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
    parameter bit          REFIN   = 1'b1,
    parameter bit          REFOUT  = 1'b1,
    parameter logic [31:0] RESIDUE = 32'h2144DF1C
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    input  logic                in_last,
    input  logic                in_abort,
    output logic                out_valid,
    output logic [31:0]         out_crc,
    output logic                out_ok,
    output logic                out_err,
    output logic [15:0]         out_bytes
);
    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t      state;
    logic [31:0] acc;
    logic [31:0] acc_next;
    logic [31:0] acc_rev;
    logic [31:0] crc_final;
    logic [15:0] byte_cnt;
    logic [15:0] byte_cnt_next;
    logic [16:0] byte_sum;
    logic [3:0]  keep_pop;
    logic [NB-1:0] keep_inc;
    logic        keep_contig;
    logic        keep_bad;
    logic        err;

    // One byte folded MSB-first into the accumulator (normal-form CRC).
    function automatic logic [31:0] fold_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic [7:0]  d;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            d[i] = REFIN ? b[7-i] : b[i];
        end
        r = c ^ {d, 24'h000000};
        for (int k = 0; k < 8; k++) begin
            r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    // Whole beat folded in lane order in a single cycle; skipped lanes pass through.
    always_comb begin
        acc_next = acc;
        keep_pop = '0;
        for (int l = 0; l < NB; l++) begin
            if (in_keep[l]) begin
                acc_next = fold_byte(acc_next, in_data[8*l +: 8]);
                keep_pop = keep_pop + 4'd1;
            end
        end
    end

    always_comb begin
        acc_rev = '0;
        for (int i = 0; i < 32; i++) begin
            acc_rev[i] = acc_next[31-i];
        end
        crc_final = (REFOUT ? acc_rev : acc_next) ^ XOROUT;
    end

    // keep & (keep+1) is zero only for a run of ones starting at lane 0 (or no ones).
    assign keep_inc    = in_keep + NB'(1);
    assign keep_contig = ((in_keep & keep_inc) == '0);
    assign keep_bad    = in_last ? !keep_contig : !(&in_keep);

    assign byte_sum      = {1'b0, byte_cnt} + {13'h0000, keep_pop};
    assign byte_cnt_next = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            acc       <= INIT;
            byte_cnt  <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_crc   <= '0;
            out_ok    <= 1'b0;
            out_err   <= 1'b0;
            out_bytes <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE, ACC: begin
                    if (in_abort) begin
                        // abort beats a simultaneous beat: it is dropped unseen
                        state    <= IDLE;
                        acc      <= INIT;
                        byte_cnt <= '0;
                        err      <= 1'b0;
                    end else if (in_valid) begin
                        if (in_last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_crc   <= crc_final;
                            out_ok    <= (crc_final == RESIDUE);
                            out_err   <= err | keep_bad;
                            out_bytes <= byte_cnt_next;
                            acc       <= INIT;
                            byte_cnt  <= '0;
                            err       <= 1'b0;
                        end else begin
                            state    <= ACC;
                            acc      <= acc_next;
                            byte_cnt <= byte_cnt_next;
                            err      <= err | keep_bad;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    acc      <= INIT;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    acc      <= INIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_crc32_stream.sv
`timescale 1ns/1ps
module tb_crc32_stream;
    localparam logic [31:0] RES = 32'h2144DF1C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_valid, s_last, s_abort;
    int          sel;
    logic [3:0]  rdy, ov, ok, er;
    logic [31:0] crc_o [4];
    logic [15:0] byt_o [4];

    int    total = 0;
    int    bad = 0;
    int    first_stall;
    string cur = "init";

    typedef struct {
        logic [31:0] crc;
        logic [15:0] bytes;
        logic        ok;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // Instances for beat widths 8, 16, 32, 64 (index 0..3); sel picks the active one.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = 8 << g;
        crc32_stream #(.DATA_W(W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (s_valid && (sel == g)),
            .in_ready  (rdy[g]),
            .in_data   (s_data[W-1:0]),
            .in_keep   (s_keep[W/8-1:0]),
            .in_last   (s_last),
            .in_abort  (s_abort && (sel == g)),
            .out_valid (ov[g]),
            .out_crc   (crc_o[g]),
            .out_ok    (ok[g]),
            .out_err   (er[g]),
            .out_bytes (byt_o[g])
        );
    end

    // Reference: LSB-first reflected CRC-32 (0xEDB88320), inverted result.
    function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h000000, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%h expected=%h", cur, tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] c, input int n, input logic e);
        sb.push_back(exp_t'{crc: c, bytes: 16'((n > 65535) ? 65535 : n), ok: (c == RES), err: e});
    endtask

    // One clock; outputs sampled 1 ns after the edge and scored against the queue.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            if (ov[g] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 32'(ov[g]), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("crc", crc_o[g], e.crc);
                    chk("bytes", 32'(byt_o[g]), 32'(e.bytes));
                    chk("ok", 32'(ok[g]), 32'(e.ok));
                    chk("err", 32'(er[g]), 32'(e.err));
                end
            end
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic last, output int stalls);
        logic took;
        s_data = d; s_keep = k; s_last = last; s_valid = 1'b1;
        stalls = 0;
        took = 1'b0;
        while (!took && stalls < 20) begin
            took = rdy[sel];
            cyc();
            if (!took) stalls++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!took) chk("accept_timeout", 32'(took), 32'h1);
        if (last) begin
            chk("latency_out_valid", 32'(ov[sel]), 32'h1);
            chk("done_bubble_ready", 32'(rdy[sel]), 32'h0);
        end
    endtask

    task automatic frame(input logic [7:0] b[$], input logic [31:0] ec);
        int nb = 1 << sel;
        int n = b.size();
        int st;
        logic [63:0] d;
        logic [7:0]  k;
        push_exp(ec, n, 1'b0);
        if (n == 0) beat(64'h0, 8'h00, 1'b1, st);
        for (int i = 0; i < n; i += nb) begin
            d = '0; k = '0;
            for (int l = 0; l < nb && i + l < n; l++) begin
                d[8*l +: 8] = b[i+l];
                k[l] = 1'b1;
            end
            beat(d, k, (i + nb >= n), st);
            if (i == 0) first_stall = st;
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) cyc();
        chk("results_drained", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] q9[$];
        logic [7:0] qb[$];
        int st;

        q9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst = 1'b1; s_data = '0; s_keep = '0; s_valid = 1'b0; s_last = 1'b0; s_abort = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        cur = "reset";
        for (int g = 0; g < 4; g++) begin
            chk("rst_out_valid", 32'(ov[g]), 32'h0);
            chk("rst_out_crc", crc_o[g], 32'h0);
            chk("rst_out_ok", 32'(ok[g]), 32'h0);
            chk("rst_out_err", 32'(er[g]), 32'h0);
            chk("rst_out_bytes", 32'(byt_o[g]), 32'h0);
        end
        rst = 1'b0;
        cyc();
        for (int g = 0; g < 4; g++) chk("ready_after_reset", 32'(rdy[g]), 32'h1);

        cur = "w8_check"; sel = 0;
        frame(q9, 32'hCBF43926);
        idle(3);

        cur = "w32_check"; sel = 2;
        frame(q9, 32'hCBF43926);
        idle(2);

        cur = "w8_residue"; sel = 0;
        q = q9; q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        frame(q, RES);
        idle(2);
        cur = "w8_residue_flip";
        q[0] = 8'h30;
        frame(q, crc_ref(q));
        idle(2);

        cur = "w64_keep0"; sel = 3;
        q = {};
        frame(q, 32'h00000000);
        idle(2);
        cur = "w64_byte0";
        q = '{8'h00};
        frame(q, 32'hD202EF8D);
        idle(2);

        cur = "w32_abort"; sel = 2;
        beat(64'h44434241, 8'h0F, 1'b0, st);
        beat(64'h48474645, 8'h0F, 1'b0, st);
        s_abort = 1'b1; s_valid = 1'b1; s_data = 64'h4C4B4A49; s_keep = 8'h0F;
        chk("abort_ready", 32'(rdy[2]), 32'h1);
        cyc();
        s_abort = 1'b0; s_valid = 1'b0;
        idle(2);
        cur = "w32_after_abort";
        frame(q9, 32'hCBF43926);
        idle(2);

        cur = "w32_keep_nonlast"; sel = 2;
        q = '{8'h31, 8'h32, 8'h33, 8'h35, 8'h36, 8'h37, 8'h38};
        push_exp(crc_ref(q), 7, 1'b1);
        beat(64'h34333231, 8'h07, 1'b0, st);
        beat(64'h38373635, 8'h0F, 1'b1, st);
        idle(2);
        cur = "w32_keep_last_gap";
        q = '{8'h41, 8'h43};
        push_exp(crc_ref(q), 2, 1'b1);
        beat(64'h44434241, 8'h05, 1'b1, st);
        idle(2);
        cur = "w32_err_cleared";
        frame(q9, 32'hCBF43926);
        idle(2);

        cur = "w16_b2b"; sel = 1;
        q  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        qb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        frame(q, crc_ref(q));
        frame(qb, crc_ref(qb));
        chk("b2b_ready_low_cycles", 32'(first_stall), 32'h1);
        idle(2);

        cur = "w16_reset_midframe";
        beat(64'h3231, 8'h03, 1'b0, st);
        beat(64'h3433, 8'h03, 1'b0, st);
        rst = 1'b1;
        cyc(); cyc();
        for (int g = 0; g < 4; g++) begin
            chk("midrst_out_crc", crc_o[g], 32'h0);
            chk("midrst_out_ok", 32'(ok[g]), 32'h0);
            chk("midrst_out_err", 32'(er[g]), 32'h0);
            chk("midrst_out_bytes", 32'(byt_o[g]), 32'h0);
        end
        rst = 1'b0;
        cyc();
        chk("midrst_ready", 32'(rdy[1]), 32'h1);
        cur = "w16_after_reset";
        frame(q9, 32'hCBF43926);
        idle(2);

        cur = "random";
        for (int s = 0; s < 4; s++) begin
            sel = s;
            for (int f = 0; f < 3; f++) begin
                q = {};
                for (int i = 0; i < int'($urandom_range(1, 20)); i++) q.push_back(8'($urandom));
                frame(q, crc_ref(q));
            end
            idle(2);
        end

        cur = "w64_bytes_saturate"; sel = 3;
        q = {};
        for (int i = 0; i < 65600; i++) q.push_back(8'(i * 7));
        frame(q, crc_ref(q));
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/crc32_stream.md
# crc32_stream

Parametrised streaming CRC-32 engine for the Ethernet MAC datapath. It accepts a frame as beats of DATA_W bits with per-byte keep, ends each frame with a last-beat handshake, and reports the reflected, inverted FCS one cycle later. A check output flags the CRC-32 residue, so the same block serves TX FCS generation and RX FCS verification. It generalises the byte-wide GMII CRC to 8/16/32/64-bit beats, partial final beats, abort and error reporting.

## Interface
- DATA_W, 8: beat width in bits; legal values 8, 16, 32, 64.
- POLY, 32'h04C11DB7: generator polynomial, normal form.
- INIT, 32'hFFFFFFFF: accumulator value at frame start.
- XOROUT, 32'hFFFFFFFF: final XOR applied after output reflection.
- REFIN, 1: 1 = each byte is processed LSB first.
- REFOUT, 1: 1 = the 32-bit result is bit-reversed before XOROUT.
- RESIDUE, 32'h2144DF1C: out_crc value that means a good frame, with FCS included.
- clk  in  1  clock. Reset rst is synchronous, active-high; clock clk.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_data  in  DATA_W  beat data; byte lane 0 = in_data[7:0] = first on wire.
- in_keep  in  DATA_W/8  byte-valid mask.
- in_last  in  1  final beat of frame.
- in_abort  in  1  discard the current frame.
- out_valid  out  1  one-cycle result strobe.
- out_crc  out  32  final CRC (after REFOUT and XOROUT).
- out_ok  out  1  out_crc == RESIDUE.
- out_err  out  1  keep violation seen in this frame.
- out_bytes  out  16  bytes counted in the frame, saturating at 16'hFFFF.

## Operation
- State machine:
  - IDLE: accumulator = INIT, byte counter = 0, err = 0. An accepted beat moves to ACC, or to DONE if in_last.
  - ACC: each accepted beat updates the accumulator. An accepted in_last beat moves to DONE.
  - DONE: out_valid = 1 for exactly one cycle, in_ready = 0. Next state is IDLE with the accumulator reloaded to INIT.
- in_ready = 1 in IDLE and ACC, 0 in DONE.
- Per-beat update:
  - Bytes are folded in lane order 0..N-1; only lanes with keep = 1 are folded.
  - Each byte is reflected when REFIN = 1 and XORed into acc[31:24].
  - Then 8 shift steps: shift left; XOR POLY when the MSB before the shift was 1.
  - The whole beat is folded in one cycle, combinationally chained.
- Keep rules:
  - A non-last beat must have keep all ones.
  - A last beat must have contiguous ones starting at lane 0; keep all zero is allowed and means no bytes.
  - Any violation sets err. The beat is still processed using its keep bits as given.
- out_bytes increases by popcount(keep) per accepted beat and saturates at 65535.
- in_abort:
  - In IDLE or ACC, the next state is IDLE, the accumulator returns to INIT and counters clear.
  - No out_valid is produced.
  - When abort and in_valid are high together, abort wins and the beat is discarded; in_ready still reads 1.
- Outputs out_crc, out_ok, out_err and out_bytes hold their last result until the next DONE.
- Reset values: out_valid 0, out_crc 0, out_ok 0, out_err 0, out_bytes 0. in_ready = 1 the cycle after reset deasserts; state = IDLE.
- Reset mid-frame drops the frame; no out_valid is produced.

## Timing
- Throughput: one beat per cycle. In back-to-back frames, the cycle after each last beat has in_ready = 0 (DONE bubble).
- Latency: an in_last beat accepted at cycle N gives out_valid at cycle N+1, with all result outputs valid in that cycle.
- The next frame's first beat can be accepted at cycle N+2.
- in_abort is sampled on the clk edge; it has no effect in DONE.

## Test plan
- DATA_W=8, ASCII "123456789", one byte per beat, last on '9' -> out_crc 32'hCBF43926, out_bytes 9, out_ok 0, out_err 0, out_valid exactly one cycle.
- DATA_W=32, same 9 bytes as beats 0x34333231 (keep F), 0x38373635 (keep F), 0x00000039 (keep 1, last) -> out_crc 32'hCBF43926, out_bytes 9.
- DATA_W=8, bytes 31..39 followed by FCS bytes 26 39 F4 CB -> out_ok 1, out_crc 32'h2144DF1C. Flipping one data bit -> out_ok 0.
- DATA_W=64, single beat with keep 0x00 and last -> out_crc 32'h00000000, out_bytes 0. Single beat 0x00 with keep 0x01 and last -> out_crc 32'hD202EF8D.
- Abort and keep errors, DATA_W=32:
  - Send 2 beats, then abort together with a valid beat -> no out_valid. The following "123456789" frame still gives 32'hCBF43926.
  - A non-last beat with keep 4'b0111 -> out_err 1 on that frame's result.
- Reset and back-to-back, DATA_W=16:
  - rst asserted mid-frame -> all outputs 0, no out_valid; the next frame is correct.
  - Two back-to-back frames -> in_ready low exactly one cycle between them, and both CRCs correct.
